wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of Wishbone requesters sharing one SDRC slave port.
REQ-002 Parameter data_width, default 32: Wishbone data width.
REQ-003 Parameter address_width, default 26: Wishbone address width.
REQ-004 Parameter TIMEOUT, default 255: maximum stb-without-ack cycles before the arbiter aborts a cycle.
REQ-005 Clocking and reset SHALL use one clock and an asynchronous, active-low reset.
REQ-006 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 wb_rst_n_i  in  1  asynchronous active-low reset.
REQ-008 m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  per-master cycle, strobe and write-enable.
REQ-009 m_addr_i  in  NUM_MASTERS*address_width  packed per-master address; master k occupies slice k.
REQ-010 m_dat_i  in  NUM_MASTERS*data_width  packed per-master write data.
REQ-011 m_sel_i  in  NUM_MASTERS*data_width/8  packed byte selects.
REQ-012 m_cti_i  in  NUM_MASTERS*3  packed cycle-type identifiers.
REQ-013 m_ack_o, m_err_o  out  NUM_MASTERS each  per-master acknowledge and abort error.
REQ-014 m_dat_o  out  data_width  read data, broadcast to all masters.
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  to the SDRC slave.
REQ-016 s_addr_o, s_dat_o, s_sel_o, s_cti_o  out  address_width, data_width, data_width/8 and 3  to the SDRC slave.
REQ-017 s_ack_i, s_dat_i  in  1 and data_width  from the SDRC slave.
REQ-018 grant_o  out  NUM_MASTERS  one-hot registered grant; all zero when no grant is held.

Function
REQ-019 FSM states SHALL be IDLE, BUSY and ABORT.
REQ-020 In IDLE with any m_cyc_i high, the arbiter SHALL grant the first requester at or after rr_ptr, searching upward modulo NUM_MASTERS.
- The grant registers on the next edge and the FSM moves to BUSY.
REQ-021 Latency SHALL be exactly one cycle from m_cyc_i sampled high in IDLE to s_cyc_o high.
REQ-022 In BUSY, the granted master's cyc, stb, we, addr, dat, sel and cti SHALL drive the s_* outputs combinationally.
REQ-023 m_dat_o SHALL equal s_dat_i at all times.
REQ-024 s_ack_i SHALL be routed only to the granted master's m_ack_o; all other m_ack_o bits SHALL be 0.
REQ-025 The grant SHALL persist for as long as the granted master holds m_cyc_i high, including across multiple stb/ack beats and bursts.
- Other requests SHALL NOT preempt it.
REQ-026 When the granted m_cyc_i is low in BUSY:
- the FSM returns to IDLE;
- grant_o clears;
- rr_ptr becomes (granted index + 1) mod NUM_MASTERS.
- A new grant needs at least one IDLE cycle.
REQ-027 A 9-bit timeout counter SHALL clear on s_ack_i, on stb low, and outside BUSY.
- It increments each BUSY cycle with s_stb_o high and s_ack_i low.
REQ-028 When the counter reaches TIMEOUT:
- the granted m_err_o pulses for one cycle;
- the FSM enters ABORT.
REQ-029 In ABORT:
- s_cyc_o and s_stb_o are 0;
- s_ack_i is ignored;
- the FSM returns to IDLE (with the rr_ptr update) once the granted m_cyc_i goes low.
REQ-030 In IDLE and ABORT, all s_* outputs SHALL be 0.
REQ-031 If s_ack_i arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: m_ack_o asserts, m_err_o stays low, and the FSM stays in BUSY.
REQ-032 If m_stb_i is low while m_cyc_i is high, the grant SHALL be held and the counter SHALL stay cleared.

Reset
REQ-033 Asserting wb_rst_n_i low SHALL immediately force the following, including mid-transaction:
- FSM = IDLE;
- grant_o = 0;
- rr_ptr = 0;
- timeout counter = 0;
- m_ack_o = 0 and m_err_o = 0;
- all s_* outputs = 0.
REQ-034 After reset deasserts, the first arbitration SHALL start from master 0.

Verification
REQ-035 Single requester: master 2 writes addr 0x0000100, data 0xDEADBEEF, slave acks 3 cycles later.
- s_cyc_o is high 1 cycle after m_cyc_i[2].
- m_ack_o = 4'b0100 for exactly one cycle.
- grant_o = 4'b0000 one cycle after cyc drops.
REQ-036 Round-robin: all four m_cyc_i are held high, and each master drops cyc after one acked beat.
- Grant order is 0,1,2,3,0, with one IDLE cycle between grants.
REQ-037 Lock: master 1 holds cyc for a 4-beat burst (cti 3'b010, then 3'b111) while master 0 requests.
- Master 0 is not granted until master 1's cyc drops.
- Master 0's m_ack_o stays 0 throughout.
REQ-038 Timeout: the slave never acks master 3 and TIMEOUT = 255.
- m_err_o[3] pulses at stb cycle 256.
- s_cyc_o drops the same cycle.
- The FSM waits in ABORT until m_cyc_i[3] falls.
REQ-039 Ack/timeout collision: s_ack_i arrives in the cycle the counter hits TIMEOUT.
- The result is m_ack_o only, no m_err_o, and the FSM remains in BUSY.
REQ-040 Reset mid-burst: wb_rst_n_i is pulled low asynchronously during master 2's BUSY.
- All outputs are 0 before the next clock edge.
- After release with all masters requesting, master 0 is granted first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one SDRC slave port.
// The grant is locked for the whole m_cyc_i period, and a stalled strobe is aborted after TIMEOUT cycles.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int data_width    = 32,
    parameter int address_width = 26,
    parameter int TIMEOUT       = 255
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*address_width-1:0]  m_addr_i,
    input  logic [NUM_MASTERS*data_width-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*data_width/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic [data_width-1:0]                 m_dat_o,
    output logic                                  s_cyc_o,
    output logic                                  s_stb_o,
    output logic                                  s_we_o,
    output logic [address_width-1:0]             s_addr_o,
    output logic [data_width-1:0]                 s_dat_o,
    output logic [data_width/8-1:0]               s_sel_o,
    output logic [2:0]                            s_cti_o,
    input  logic                                  s_ack_i,
    input  logic [data_width-1:0]                 s_dat_i,
    output logic [NUM_MASTERS-1:0]                grant_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = data_width / 8;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [8:0]             tmo_q, tmo_d;

    logic                     pick_found;
    logic [IW-1:0]            pick_idx;
    logic [IW-1:0]            next_ptr;
    logic                     g_cyc, g_stb, g_we;
    logic [address_width-1:0] g_addr;
    logic [data_width-1:0]    g_dat;
    logic [SW-1:0]            g_sel;
    logic [2:0]               g_cti;
    logic                     busy, tmo_hit, err_fire;

    // First requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            int            c;
            logic [IW-1:0] cidx;
            c = int'(rr_ptr_q) + i;
            if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
            cidx = IW'(c);
            if (!pick_found && m_cyc_i[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    always_comb begin
        int nx;
        nx = int'(gidx_q) + 1;
        if (nx >= NUM_MASTERS) nx = 0;
        next_ptr = IW'(nx);
    end

    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_addr = '0;
        g_dat  = '0;
        g_sel  = '0;
        g_cti  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gidx_q == IW'(k)) begin
                g_cyc  = m_cyc_i[k];
                g_stb  = m_stb_i[k];
                g_we   = m_we_i[k];
                g_addr = m_addr_i[k*address_width +: address_width];
                g_dat  = m_dat_i[k*data_width +: data_width];
                g_sel  = m_sel_i[k*SW +: SW];
                g_cti  = m_cti_i[k*3 +: 3];
            end
        end
    end

    assign busy     = (state_q == BUSY);
    assign tmo_hit  = (tmo_q == 9'(TIMEOUT));
    // A same-cycle ack beats the timeout, so the error only fires on a still-stalled strobe.
    assign err_fire = busy && g_cyc && g_stb && tmo_hit && !s_ack_i;

    assign s_cyc_o  = busy && g_cyc;
    assign s_stb_o  = busy && g_stb;
    assign s_we_o   = busy && g_we;
    assign s_addr_o = busy ? g_addr : '0;
    assign s_dat_o  = busy ? g_dat  : '0;
    assign s_sel_o  = busy ? g_sel  : '0;
    assign s_cti_o  = busy ? g_cti  : '0;
    assign m_ack_o  = busy ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
    assign m_err_o  = err_fire ? grant_q : '0;
    assign m_dat_o  = s_dat_i;
    assign grant_o  = grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        tmo_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gidx_d  = pick_idx;
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if (err_fire) begin
                    state_d = ABORT;
                end else if (g_stb && !s_ack_i) begin
                    tmo_d = tmo_q + 9'd1;
                end
            end
            ABORT: begin
                if (!g_cyc) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: expected grant indices are queued as requests are
// raised and popped when the arbiter issues each grant.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 26;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_dat;
    logic [N*DW/8-1:0] m_sel;
    logic [N*3-1:0]    m_cti;
    logic [N-1:0]      m_ack, m_err;
    logic [DW-1:0]     m_dat_rd;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_dat;
    logic [DW/8-1:0]   s_sel;
    logic [2:0]        s_cti;
    logic              s_ack;
    logic [DW-1:0]     s_dat_rd;
    logic [N-1:0]      grant;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    wb_rr_arbiter #(.NUM_MASTERS(N), .data_width(DW), .address_width(AW), .TIMEOUT(255)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_rd),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_cti_o(s_cti),
        .s_ack_i(s_ack), .s_dat_i(s_dat_rd), .grant_o(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
        s_ack = 1'b0; s_dat_rd = '0;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] dat, input logic [2:0] cti);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_addr[k*AW +: AW] = addr;
        m_dat[k*DW +: DW]  = dat;
        m_sel[k*4 +: 4]    = 4'hF;
        m_cti[k*3 +: 3]    = cti;
    endtask

    // Bounded wait for a non-zero grant, then pop and compare against the scoreboard.
    task automatic wait_and_pop(input string name);
        int n;
        int e;
        n = 0;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: grant %b seen with empty scoreboard", name, grant);
        end else begin
            e = exp_q.pop_front();
            if (grant !== (4'b0001 << e)) begin
                errors++;
                $display("[TB] FAIL %s: grant_o=%b expected=%b", name, grant, 4'b0001 << e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_cyc = '1; m_stb = '1; s_ack = 1'b1;
        #3;
        checks++;
        if ({grant, m_ack, m_err, s_cyc, s_stb} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got grant=%b ack=%b err=%b cyc=%b stb=%b expected all 0",
                     grant, m_ack, m_err, s_cyc, s_stb);
        end
        do_reset();
        checks++;
        if (grant !== 4'b0000 || s_cyc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: grant=%b s_cyc=%b expected 0000/0", grant, s_cyc);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_master(2, 1'b1, 1'b1, 1'b1, 26'h0000100, 32'hDEADBEEF, 3'b000);
        exp_q.push_back(2);
        step();
        checks++;
        if (s_cyc !== 1'b1 || s_addr !== 26'h0000100 || s_dat !== 32'hDEADBEEF || s_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_route: cyc=%b addr=%h dat=%h we=%b expected 1/0000100/deadbeef/1",
                     s_cyc, s_addr, s_dat, s_we);
        end
        wait_and_pop("single_grant");
        step();
        step();
        s_ack = 1'b1;
        s_dat_rd = 32'h1234_5678;
        #1;
        checks++;
        if (m_ack !== 4'b0100 || m_dat_rd !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL single_ack: m_ack=%b m_dat=%h expected 0100/12345678", m_ack, m_dat_rd);
        end
        step();
        s_ack = 1'b0;
        set_master(2, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        #1;
        checks++;
        if (m_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_ack_once: m_ack=%b expected 0000", m_ack);
        end
        step();
        checks++;
        if (grant !== 4'b0000 || s_cyc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: grant=%b s_cyc=%b expected 0000/0", grant, s_cyc);
        end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int k = 0; k < N; k++) set_master(k, 1'b1, 1'b1, 1'b0, AW'(32'h40 * (k + 1)), '0, 3'b000);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int beat = 0; beat < 5; beat++) begin
            wait_and_pop("rr_grant");
            g = 0;
            for (int k = 0; k < N; k++) if (grant[k]) g = k;
            checks++;
            if (s_addr !== AW'(32'h40 * (g + 1))) begin
                errors++;
                $display("[TB] FAIL rr_addr: s_addr=%h expected=%h", s_addr, AW'(32'h40 * (g + 1)));
            end
            s_ack = 1'b1;
            #1;
            checks++;
            if (m_ack !== grant) begin
                errors++;
                $display("[TB] FAIL rr_ack: m_ack=%b expected=%b", m_ack, grant);
            end
            step();
            s_ack = 1'b0;
            m_cyc[g] = 1'b0;
            m_stb[g] = 1'b0;
            step();
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL rr_idle_gap: grant=%b expected 0000", grant);
            end
            m_cyc[g] = 1'b1;
            m_stb[g] = 1'b1;
            step();
        end
        m_cyc = '0; m_stb = '0;
        step();
    endtask

    task automatic test_lock();
        logic [2:0] cti_seq [4];
        cti_seq[0] = 3'b010; cti_seq[1] = 3'b010; cti_seq[2] = 3'b010; cti_seq[3] = 3'b111;
        do_reset();
        set_master(1, 1'b1, 1'b1, 1'b0, 26'h200, '0, cti_seq[0]);
        exp_q.push_back(1);
        step();
        wait_and_pop("lock_grant1");
        set_master(0, 1'b1, 1'b1, 1'b1, 26'h300, 32'hCAFE0000, 3'b000);
        for (int b = 0; b < 4; b++) begin
            m_cti[1*3 +: 3] = cti_seq[b];
            s_ack = 1'b1;
            #1;
            checks++;
            if (grant !== 4'b0010 || m_ack !== 4'b0010 || s_cti !== cti_seq[b]) begin
                errors++;
                $display("[TB] FAIL lock_beat%0d: grant=%b m_ack=%b cti=%b expected 0010/0010/%b",
                         b, grant, m_ack, s_cti, cti_seq[b]);
            end
            step();
        end
        s_ack = 1'b0;
        set_master(1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        exp_q.push_back(0);
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL lock_idle: grant=%b expected 0000", grant);
        end
        step();
        wait_and_pop("lock_grant0");
        m_cyc = '0; m_stb = '0;
        step();
    endtask

    task automatic test_stb_hold();
        bit seen_err;
        do_reset();
        set_master(1, 1'b1, 1'b1, 1'b0, 26'h10, '0, 3'b000);
        exp_q.push_back(1);
        step();
        wait_and_pop("hold_grant");
        seen_err = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (m_err !== '0) seen_err = 1'b1;
            step();
        end
        m_stb[1] = 1'b0;
        step();
        step();
        checks++;
        if (grant !== 4'b0010 || s_cyc !== 1'b1 || s_stb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_grant_kept: grant=%b cyc=%b stb=%b expected 0010/1/0", grant, s_cyc, s_stb);
        end
        m_stb[1] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #0;
            if (m_err !== '0) seen_err = 1'b1;
            step();
        end
        checks++;
        if (seen_err) begin
            errors++;
            $display("[TB] FAIL hold_counter_clear: m_err pulsed, expected none");
        end
        m_cyc = '0; m_stb = '0;
        step();
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        set_master(3, 1'b1, 1'b1, 1'b0, 26'h3FF, '0, 3'b000);
        exp_q.push_back(3);
        step();
        wait_and_pop("tmo_grant");
        early = 1'b0;
        for (int k = 1; k < 256; k++) begin
            if (m_err !== '0) early = 1'b1;
            step();
        end
        checks++;
        if (early || m_err !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL tmo_err: early=%0d m_err=%b expected pulse 1000 at stb cycle 256", early, m_err);
        end
        step();
        s_ack = 1'b1;
        #1;
        checks++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m_err !== 4'b0000 || m_ack !== 4'b0000 || grant !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL tmo_abort: cyc=%b stb=%b err=%b ack=%b grant=%b expected 0/0/0000/0000/1000",
                     s_cyc, s_stb, m_err, m_ack, grant);
        end
        repeat (3) step();
        s_ack = 1'b0;
        checks++;
        if (grant !== 4'b1000 || s_cyc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_wait: grant=%b cyc=%b expected 1000/0", grant, s_cyc);
        end
        m_cyc = '0; m_stb = '0;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL tmo_release: grant=%b expected 0000", grant);
        end
    endtask

    task automatic test_collision();
        do_reset();
        set_master(0, 1'b1, 1'b1, 1'b1, 26'h55, 32'h0BADF00D, 3'b000);
        exp_q.push_back(0);
        step();
        wait_and_pop("col_grant");
        for (int k = 1; k < 256; k++) step();
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 4'b0001 || m_err !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL col_ack_wins: m_ack=%b m_err=%b expected 0001/0000", m_ack, m_err);
        end
        step();
        s_ack = 1'b0;
        #1;
        checks++;
        if (s_cyc !== 1'b1 || grant !== 4'b0001 || m_err !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL col_stay_busy: cyc=%b grant=%b err=%b expected 1/0001/0000", s_cyc, grant, m_err);
        end
        m_cyc = '0; m_stb = '0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_master(2, 1'b1, 1'b1, 1'b1, 26'h777, 32'hA5A5A5A5, 3'b010);
        exp_q.push_back(2);
        step();
        wait_and_pop("rstmid_grant");
        s_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, m_ack, m_err, s_cyc, s_stb, s_we} !== '0 || s_addr !== '0 || s_dat !== '0 ||
            s_sel !== '0 || s_cti !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: grant=%b ack=%b err=%b cyc=%b stb=%b addr=%h expected all 0",
                     grant, m_ack, m_err, s_cyc, s_stb, s_addr);
        end
        s_ack = 1'b0;
        for (int k = 0; k < N; k++) set_master(k, 1'b1, 1'b1, 1'b0, AW'(k), '0, 3'b000);
        exp_q.delete();
        exp_q.push_back(0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        wait_and_pop("rstmid_first");
        m_cyc = '0; m_stb = '0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
        s_ack = 1'b0; s_dat_rd = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stb_hold();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
